// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store sequencer: size codes, address regions
// and FSM state encodings.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    RG_RAM = 2'd0,
    RG_LED = 2'd1,
    RG_SW  = 2'd2,
    RG_BAD = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of byte cycles a request of the given size code needs.
  function automatic logic [3:0] bytes_of(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline-side request/response signals and the byte-wide
// memory-side port. The slave modport is the sequencer's view.
interface mem_access_unit_if #(parameter int ADDR_W = 64);

  logic              i_req;
  logic              i_memRd;
  logic              i_memWr;
  logic [1:0]        i_size;
  logic              i_signed;
  logic [ADDR_W-1:0] i_add;
  logic [63:0]       i_dataWr;
  logic              o_busy;
  logic              o_done;
  logic              o_fault;
  logic [63:0]       o_dataRd;
  logic [ADDR_W-1:0] o_mAdd;
  logic [7:0]        o_mDataWr;
  logic              o_mRd;
  logic              o_mWr;
  logic [7:0]        i_mDataRd;

  modport slave (
    input  i_req, i_memRd, i_memWr, i_size, i_signed, i_add, i_dataWr, i_mDataRd,
    output o_busy, o_done, o_fault, o_dataRd, o_mAdd, o_mDataWr, o_mRd, o_mWr
  );

  modport master (
    output i_req, i_memRd, i_memWr, i_size, i_signed, i_add, i_dataWr, i_mDataRd,
    input  o_busy, o_done, o_fault, o_dataRd, o_mAdd, o_mDataWr, o_mRd, o_mWr
  );

endinterface

// File: rtl/mem_access_unit_ext.sv
// Combinational 64-bit sign/zero extender for assembled load data.
module mem_ext_unit
  import mem_access_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [63:0] ext_o
);

  // Replicate the top bit of the loaded quantity when signed, else pad with zeros.
  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SZ_B:    ext_o = {{56{signed_i & raw_i[7]}},  raw_i[7:0]};
      SZ_H:    ext_o = {{48{signed_i & raw_i[15]}}, raw_i[15:0]};
      SZ_W:    ext_o = {{32{signed_i & raw_i[31]}}, raw_i[31:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a byte-wide memory/MMIO port.
// Each request is split into byte-serial cycles, loads are assembled
// little-endian and extended to 64 bits.
// Optional feature: define MEM_MISALIGN_TRAP_EN to fault unaligned RAM accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_SIZE = 100,
  parameter int ADDR_W   = 64
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        n_q, n_d;
  logic [63:0]       raw_q, raw_d;
  logic [63:0]       dataRd_q, dataRd_d;
  logic              fault_q, fault_d;

  region_e           region;
  logic              reqValid;
  logic [3:0]        reqN;
  logic [1:0]        reqSize;
  logic [ADDR_W-1:0] endAddr;
  logic              rangeBad;
  logic              misBad;
  logic              reqFault;
  logic              lastByte;
  logic              accept;
  logic [63:0]       extData;

  // Decode an incoming request: byte count, effective size and fault reasons.
  // MMIO regions are single-byte registers, so they always take one cycle.
  always_comb begin
    region   = region_e'(bus.i_add[17:16]);
    reqValid = bus.i_req & (bus.i_memRd | bus.i_memWr);
    if (region == RG_LED || region == RG_SW) begin
      reqN    = 4'd1;
      reqSize = SZ_B;
    end else begin
      reqN    = bytes_of(bus.i_size);
      reqSize = bus.i_size;
    end
    endAddr  = bus.i_add + ADDR_W'(reqN);
    rangeBad = (region == RG_RAM) && (endAddr > ADDR_W'(MEM_SIZE));
`ifdef MEM_MISALIGN_TRAP_EN
    misBad   = (region == RG_RAM) && ((bus.i_add[3:0] & (reqN - 4'd1)) != 4'd0);
`else
    misBad   = 1'b0;
`endif
    reqFault = (bus.i_memRd & bus.i_memWr) || (region == RG_BAD) || rangeBad ||
               (bus.i_memWr && region == RG_SW) || misBad;
    accept   = (state_q == ST_IDLE) && reqValid;
    lastByte = (cnt_q == n_q - 4'd1);
  end

  // State register; reset returns to IDLE immediately so strobes drop at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: rejected requests skip straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (reqValid) state_d = reqFault ? ST_DONE : ST_XFER;
      ST_XFER: if (lastByte) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory-side signals are zero outside XFER.
  always_comb begin
    bus.o_busy    = (state_q == ST_XFER);
    bus.o_done    = (state_q == ST_DONE);
    bus.o_mRd     = (state_q == ST_XFER) && rd_q;
    bus.o_mWr     = (state_q == ST_XFER) && wr_q;
    bus.o_mAdd    = '0;
    bus.o_mDataWr = 8'h00;
    if (state_q == ST_XFER) begin
      bus.o_mAdd = addr_q + ADDR_W'(cnt_q);
      if (wr_q) bus.o_mDataWr = wdata_q[{cnt_q[2:0], 3'b000} +: 8];
    end
    bus.o_fault  = fault_q;
    bus.o_dataRd = dataRd_q;
  end

  // Assembly buffer: cleared on accept, one byte lane filled per load cycle.
  always_comb begin
    raw_d = raw_q;
    if (accept) raw_d = '0;
    else if (state_q == ST_XFER && rd_q) raw_d[{cnt_q[2:0], 3'b000} +: 8] = bus.i_mDataRd;
  end

  mem_ext_unit u_ext (
    .raw_i    (raw_d),
    .size_i   (size_q),
    .signed_i (sgn_q),
    .ext_o    (extData)
  );

  // Request latch, byte counter and result registers.
  // The final load byte goes straight through the extender so the result is
  // ready in the DONE cycle.
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    dataRd_d = dataRd_q;
    fault_d  = fault_q;
    if (accept) begin
      addr_d   = bus.i_add;
      size_d   = reqSize;
      sgn_d    = bus.i_signed;
      rd_d     = bus.i_memRd;
      wr_d     = bus.i_memWr;
      wdata_d  = bus.i_dataWr;
      cnt_d    = 4'd0;
      n_d      = reqN;
      dataRd_d = '0;
      fault_d  = reqFault;
    end else if (state_q == ST_XFER) begin
      cnt_d = cnt_q + 4'd1;
      if (lastByte && rd_q) dataRd_d = extData;
    end
  end

  // Datapath registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      size_q   <= 2'd0;
      sgn_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= 4'd0;
      n_q      <= 4'd0;
      raw_q    <= '0;
      dataRd_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      raw_q    <= raw_d;
      dataRd_q <= dataRd_d;
      fault_q  <= fault_d;
    end
  end

endmodule
